digit_scan_mux: RTL
===================

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed display digits; legal range 2..8.
REQ-002 Parameter DIGIT_WIDTH, default 4: bits per digit value.
REQ-003 Parameter SCAN_DIV, default 1000: clocks per digit slot; legal range >= 2.
REQ-004 Local CW = $clog2(NUM_DIGITS): digit counter width.
REQ-005 clk  input  1  single system clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 digits  input  NUM_DIGITS*DIGIT_WIDTH  packed digit values; digit i at bits [i*DIGIT_WIDTH +: DIGIT_WIDTH]; digit 0 = LSB.
REQ-008 load  input  1  sample digits into the pending buffer this cycle.
REQ-009 blank_lz  input  1  live leading-zero blanking enable.
REQ-010 value  output  DIGIT_WIDTH  value of the digit currently driven.
REQ-011 digitCount  output  CW  index of the digit currently driven; NUM_DIGITS-1 = MSB, 0 = LSB.
REQ-012 digit_en  output  NUM_DIGITS  active-high digit enable; one-hot or all-zero.
REQ-013 frame_done  output  1  one-cycle pulse marking completion of a full scan.

Function
REQ-014 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; tick = (prescaler == SCAN_DIV-1).
REQ-015 Digit counter cnt decrements on tick; cnt==0 with tick wraps to NUM_DIGITS-1, which is the wrap event; scan order MSB first.
REQ-016 Pending buffer captures digits on every cycle with load=1 and sets pending_valid; the last load before transfer wins.
REQ-017 On a wrap event, the display register takes the pending buffer if pending_valid=1, and pending_valid clears.
REQ-018 load=1 on the wrap-event cycle writes digits directly into the display register and leaves pending_valid=0.
REQ-019 The display register never changes except on a wrap event, so no frame mixes old and new data.
REQ-020 Digit i is blanked iff blank_lz=1, i != 0, and every display digit j >= i equals zero; digit 0 is never blanked.
REQ-021 Every output is registered and updates one clock after the state it reflects.
REQ-022 Each edge: value <= display[cnt]; digitCount <= cnt; digit_en <= blanked(cnt) ? 0 : (1 << cnt).
REQ-023 frame_done <= wrap event, giving a one-cycle high one clock after the cnt 0 -> NUM_DIGITS-1 transition.
REQ-024 value reports the digit (zero) even when that digit is blanked; only digit_en goes dark.
REQ-025 Each digit slot lasts exactly SCAN_DIV clocks; a frame lasts NUM_DIGITS*SCAN_DIV clocks.
REQ-026 Non-power-of-2 NUM_DIGITS: cnt never takes values >= NUM_DIGITS.

Reset
REQ-027 Asserting reset immediately forces: prescaler=0, cnt=NUM_DIGITS-1, display=0, pending=0, pending_valid=0, value=0, digitCount=0, digit_en=0, frame_done=0.
REQ-028 Reset mid-frame discards pending data; scanning restarts at the MSB slot on the first clock after deassertion.
REQ-029 After deassertion the first clock drives digitCount=NUM_DIGITS-1; the MSB slot lasts SCAN_DIV clocks from there.

Verification (NUM_DIGITS=4, DIGIT_WIDTH=4, SCAN_DIV=4)
REQ-030 Reset, blank_lz=0, no load -> digitCount 3,2,1,0 in 4-clock slots; digit_en 1000,0100,0010,0001; value=0; frame_done pulses every 16 clocks.
REQ-031 load with digits=16'h1234 mid-frame -> current frame still shows 0; from the next frame value = 1,2,3,4 in slots 3,2,1,0.
REQ-032 blank_lz=1, display 16'h0050 -> slots 3,2 digit_en=0000; slot 1 value=5 digit_en=0010; slot 0 value=0 digit_en=0001. Display 16'h0000 -> only slot 0 lit.
REQ-033 Loads 16'hAAAA then 16'h5555 in one frame -> next frame shows 5,5,5,5. load of 16'h9876 on the wrap cycle -> the frame starting then shows 9,8,7,6.
REQ-034 Assert reset during slot 1 with a pending load -> outputs 0 asynchronously; after release, the old pending data never appears and the scan restarts at digitCount=3.
REQ-035 Toggle blank_lz mid-slot with display 16'h0007 -> digit_en for slots 3..1 changes on the next clock; digitCount timing is unaffected.

Source files
------------

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit driver: scans MSB first, one digit per SCAN_DIV clocks.
// All outputs registered (one clock behind internal state); no backpressure, loads always accepted.
module digit_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_WIDTH = 4,
    parameter int SCAN_DIV    = 1000,
    localparam int CW         = $clog2(NUM_DIGITS),
    localparam int PW         = $clog2(SCAN_DIV)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] digits,
    input  logic                              load,
    input  logic                              blank_lz,
    output logic [DIGIT_WIDTH-1:0]            value,
    output logic [CW-1:0]                     digitCount,
    output logic [NUM_DIGITS-1:0]             digit_en,
    output logic                              frame_done
);

    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);

    logic [PW-1:0]                     r_presc;
    logic [CW-1:0]                     r_cnt;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] r_display;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] r_pend;
    logic                              r_pend_vld;
    logic [DIGIT_WIDTH-1:0]            r_value;
    logic [CW-1:0]                     r_digit_count;
    logic [NUM_DIGITS-1:0]             r_digit_en;
    logic                              r_frame_done;

    logic                              w_tick;
    logic                              w_wrap;
    logic [DIGIT_WIDTH-1:0]            w_disp [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]             w_allz;
    logic [NUM_DIGITS-1:0]             w_onehot;
    logic                              w_blank;
    logic                              w_acc;

    assign w_tick = (r_presc == LAST_PRESC);
    assign w_wrap = w_tick && (r_cnt == '0);

    // w_allz[i]: display digits i..MSB are all zero
    always_comb begin
        w_allz   = '0;
        w_onehot = '0;
        w_acc    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_disp[i] = r_display[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            w_acc     = w_acc && (w_disp[i] == '0);
            w_allz[i] = w_acc;
        end
        w_onehot[r_cnt] = 1'b1;
        w_blank = blank_lz && (r_cnt != '0) && w_allz[r_cnt];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc       <= '0;
            r_cnt         <= LAST_DIGIT;
            r_display     <= '0;
            r_pend        <= '0;
            r_pend_vld    <= 1'b0;
            r_value       <= '0;
            r_digit_count <= '0;
            r_digit_en    <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_cnt <= (r_cnt == '0) ? LAST_DIGIT : r_cnt - 1'b1;
            end

            // Display only changes at the frame boundary; a load landing exactly there bypasses the buffer.
            if (w_wrap) begin
                r_pend_vld <= 1'b0;
                if (load) begin
                    r_display <= digits;
                end else if (r_pend_vld) begin
                    r_display <= r_pend;
                end
            end else if (load) begin
                r_pend     <= digits;
                r_pend_vld <= 1'b1;
            end

            r_value       <= w_disp[r_cnt];
            r_digit_count <= r_cnt;
            r_digit_en    <= w_blank ? '0 : w_onehot;
            r_frame_done  <= w_wrap;
        end
    end

    assign value      = r_value;
    assign digitCount = r_digit_count;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule
